key_expansion_seq: RTL and testbench

//  Iterative AES key schedule for AES-128/192/256. Generates one 32-bit word w[i] per cycle
//  and hands out round keys (4 words) in order over a valid/ready stream. The Rcon word

---
 rtl/key_expansion_seq.sv | 160 ++++++++++++++++
 tb/tb_key_expansion_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule (AES-128/192/256): one 32-bit word per cycle,
// with round keys handed out over a valid/ready stream.
module key_expansion_seq #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_round,
  output logic             done
);

  localparam int         NR         = NK + 6;
  localparam logic [5:0] NK_W       = 6'(NK);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {IDLE, GEN, HOLD, FIN} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as x^254 by repeated squaring (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] j);
    case (j)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e         state_q;
  logic [5:0]     i_q;
  logic [31:0]    window_q [NK];
  logic [95:0]    asm_q;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_round_q;
  logic           rk_valid_q;
  logic           busy_q;
  logic           done_q;

  logic [5:0]     i_div;
  logic [5:0]     i_mod;
  logic [31:0]    t;
  logic [31:0]    w_d;

  // window_q[0] is w[i-NK], window_q[NK-1] is w[i-1]. While i<NK the window
  // just rotates the loaded key, so window_q[0] is always the word to emit or XOR.
  // NOTE: combinational logic uses blocking '='; only always_ff uses '<='.
  always_comb begin
    i_div = i_q / NK_W;
    i_mod = i_q % NK_W;
    t     = window_q[NK-1];
    if (i_mod == 6'd0) begin
      t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i_div), 24'h0};
    end else if (NK == 8 && i_mod == 6'd4) begin
      t = sub_word(t);
    end
    w_d = (i_q < NK_W) ? window_q[0] : (window_q[0] ^ t);
  end

  // NOTE: the key window is a handful of flops, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      for (int k = 0; k < NK; k++) window_q[k] <= '0;
      asm_q      <= '0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) window_q[k] <= key_in[32*(NK-k)-1 -: 32];
            i_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= GEN;
          end
        end
        GEN: begin
          for (int k = 0; k < NK - 1; k++) window_q[k] <= window_q[k+1];
          window_q[NK-1] <= w_d;
          asm_q          <= {asm_q[63:0], w_d};
          // i stops on the very last word so it never leaves 0..TW-1.
          i_q <= (i_q[1:0] == 2'd3 && i_q[5:2] == LAST_ROUND) ? i_q : i_q + 6'd1;
          if (i_q[1:0] == 2'd3) begin
            rk_data_q  <= {asm_q, w_d};
            rk_round_q <= i_q[5:2];
            rk_valid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (rk_ready) begin
            rk_valid_q <= 1'b0;
            if (rk_round_q == LAST_ROUND) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= GEN;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_round = rk_round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: one instance per key size (NK=4/6/8), known-answer
// vectors, random keys with random back-pressure, ignored restarts and mid-run reset.
module tb_key_expansion_seq;

  logic         clk;
  logic         rst_n;
  logic [255:0] key_bus;
  logic         start_s  [3];
  logic         ready_s  [3];
  logic         busy_s   [3];
  logic         valid_s  [3];
  logic         done_s   [3];
  logic [127:0] data_s   [3];
  logic [3:0]   round_s  [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [256];
  logic [31:0]  mw     [60];
  logic [127:0] got    [15];

  typedef struct {
    int           nk;
    logic [255:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  key_expansion_seq #(.NK(4)) u_nk4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .key_in(key_bus[127:0]),
    .busy(busy_s[0]), .rk_valid(valid_s[0]), .rk_ready(ready_s[0]),
    .rk_data(data_s[0]), .rk_round(round_s[0]), .done(done_s[0]));

  key_expansion_seq #(.NK(6)) u_nk6 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .key_in(key_bus[191:0]),
    .busy(busy_s[1]), .rk_valid(valid_s[1]), .rk_ready(ready_s[1]),
    .rk_data(data_s[1]), .rk_round(round_s[1]), .done(done_s[1]));

  key_expansion_seq #(.NK(8)) u_nk8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .key_in(key_bus),
    .busy(busy_s[2]), .rk_valid(valid_s[2]), .rk_ready(ready_s[2]),
    .rk_data(data_s[2]), .rk_round(round_s[2]), .done(done_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (straight FIPS-197 key expansion) ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    while (b != 8'h00) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c = 8'h63;
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = m_sub(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic check_reset_outs(input string name, input int idx);
    check(name, 256'({busy_s[idx], valid_s[idx], done_s[idx], round_s[idx], data_s[idx]}), 256'(0));
  endtask

  // One full schedule on the instance for 'nk'. Inputs change and outputs are
  // sampled 1 ns after each rising edge; cyc counts edges after the start edge.
  task automatic run_and_check(input int nk, input logic [255:0] key, input bit rnd_ready,
                               input bit poke, input string tag);
    int           idx = (nk - 4) / 2;
    int           nr = nk + 6;
    int           cyc = 0, got_n = 0, done_cyc = -1, last_acc = -10;
    int           stab_bad = 0, seq_bad = 0, busy_bad = 0, time_bad = 0;
    bit           held = 1'b0, finished = 1'b0;
    logic [127:0] held_data = '0;
    logic [3:0]   held_round = '0;

    expand(nk, key);
    key_bus        = key;
    start_s[idx]   = 1'b1;
    ready_s[idx]   = 1'b0;
    @(posedge clk); #1;
    start_s[idx]   = 1'b0;

    while (!finished && cyc < 1000) begin
      if (held && !(valid_s[idx] && data_s[idx] == held_data && round_s[idx] == held_round))
        stab_bad++;
      held = 1'b0;
      if (done_s[idx]) begin
        finished = 1'b1;
        done_cyc = cyc;
        if (busy_s[idx]) busy_bad++;
      end else begin
        if (!busy_s[idx]) busy_bad++;
        ready_s[idx] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (valid_s[idx]) begin
          if (ready_s[idx]) begin
            if (int'(round_s[idx]) != got_n) seq_bad++;
            if (got_n < 15) got[got_n] = data_s[idx];
            if (!rnd_ready && cyc != 4 + 5*got_n) time_bad++;
            got_n++;
            last_acc = cyc;
          end else begin
            held       = 1'b1;
            held_data  = data_s[idx];
            held_round = round_s[idx];
          end
        end
        start_s[idx] = poke && (cyc == 2 || cyc == 4 || cyc % 7 == 3);
        key_bus      = poke ? ~key : key;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_s[idx] = 1'b0;
    ready_s[idx] = 1'b0;

    check({tag, "_finished"}, 256'(finished), 256'(1));
    check({tag, "_key_count"}, 256'(got_n), 256'(nr + 1));
    for (int r = 0; r <= nr && r < got_n; r++)
      check($sformatf("%s_r%0d", tag, r), 256'(got[r]), 256'(model_rk(r)));
    check({tag, "_stable_while_stalled"}, 256'(stab_bad), 256'(0));
    check({tag, "_round_order"}, 256'(seq_bad), 256'(0));
    check({tag, "_busy"}, 256'(busy_bad), 256'(0));
    check({tag, "_done_after_last_accept"}, 256'(done_cyc), 256'(last_acc + 1));
    if (!rnd_ready) begin
      check({tag, "_key_spacing"}, 256'(time_bad), 256'(0));
      check({tag, "_done_latency"}, 256'(done_cyc), 256'(5*nr + 5));
    end
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 256'({done_s[idx], busy_s[idx]}), 256'(0));
  endtask

  vec_t         vecs [7];
  logic [255:0] k1, k2, k3, knew;
  int           wcyc;

  initial begin
    k1 = 256'(128'h2b7e151628aed2a6abf7158809cf4f3c);
    k2 = 256'(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
    k3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    vecs[0] = '{4, k1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{4, k1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{4, k1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{6, k2, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[4] = '{6, k2, 12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[5] = '{8, k3, 0,  128'h603deb1015ca71be2b73aef0857d7781};
    vecs[6] = '{8, k3, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    build_sbox();
    rst_n   = 1'b0;
    key_bus = '0;
    for (int j = 0; j < 3; j++) begin
      start_s[j] = 1'b0;
      ready_s[j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) check_reset_outs($sformatf("reset_state_%0d", j), j);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors with rk_ready tied high.
    for (int v = 0; v < 7; v++) begin
      run_and_check(vecs[v].nk, vecs[v].key, 1'b0, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_known_r%0d", v, vecs[v].round),
            256'(got[vecs[v].round]), 256'(vecs[v].exp));
    end

    // Back-pressure, ignored restarts in GEN and HOLD, then random keys.
    run_and_check(4, k1, 1'b1, 1'b0, "k1_backpressure");
    check("k1_backpressure_r10", 256'(got[10]), 256'(vecs[2].exp));
    run_and_check(4, k1, 1'b0, 1'b1, "k1_restart_ignored");
    check("k1_restart_r1", 256'(got[1]), 256'(vecs[1].exp));
    run_and_check(8, k3, 1'b1, 1'b1, "k3_restart_ignored");
    for (int n = 0; n < 2; n++) begin
      run_and_check(4, rand_key(), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd4_%0d", n));
      run_and_check(6, rand_key(), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd6_%0d", n));
      run_and_check(8, rand_key(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $sformatf("rnd8_%0d", n));
    end

    // Asynchronous reset while round 5 is being offered, then a fresh key.
    key_bus    = k1;
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wcyc = 0;
    while (!(valid_s[0] && round_s[0] == 4'd5) && wcyc < 200) begin
      @(posedge clk); #1;
      wcyc++;
    end
    check("midrun_reached_r5", 256'({valid_s[0], round_s[0]}), 256'({1'b1, 4'd5}));
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrun_reset_async", 0);
    @(posedge clk); #1;
    check_reset_outs("midrun_reset_held", 0);
    ready_s[0] = 1'b0;
    rst_n      = 1'b1;
    knew       = rand_key();
    run_and_check(4, knew, 1'b1, 1'b0, "after_reset");
    check("after_reset_r0_is_new_key", 256'(got[0]), 256'(knew[127:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
